// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared entry type, exception codes and PC legality check for instruction fetch
package ifetch_pkg;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  exc;
  } ifq_entry_t;

  function automatic logic pc_legal(input logic [31:0] pc,
                                    input logic [19:0] seg_lo,
                                    input logic [19:0] seg_hi);
    return (pc[1:0] == 2'b00) && (pc[31:12] >= seg_lo) && (pc[31:12] <= seg_hi);
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// rtl/ifq_fifo.sv - DEPTH-entry prefetch queue of tagged instruction words
// Clear dominates push and pop; push is ignored when full, pop when empty.
module ifq_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  ifq_entry_t               push_data,
  input  logic                     pop,
  output ifq_entry_t               head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  ifq_entry_t      mem_q [DEPTH];
  ifq_entry_t      mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: only entries below count are ever visible.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/ifetch_prefetch_queue.sv
// rtl/ifetch_prefetch_queue.sv - fetch PC, issue control, discard and redirect mux in front of the prefetch queue
// Optional macro IFQ_BYPASS_EN: forward a response straight to ID when the queue is empty and ID is ready.
module ifetch_prefetch_queue
  import ifetch_pkg::*;
#(
  parameter int          DEPTH      = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [19:0] SEG_LO     = 20'h00003,
  parameter logic [19:0] SEG_HI     = 20'h00004
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        eret_valid,
  input  logic [31:0] epc,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [4:0]  if_exccode
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        inflight_q, inflight_d;
  logic        discard_q, discard_d;
  logic        halt_q, halt_d;

  logic        redirect_any;
  logic [31:0] redirect_target;
  logic        pc_ok, slot_ok, rsp_fire, rsp_keep, req_fire, adel_push, bypass;

  logic        fifo_clear, fifo_push, fifo_pop, fifo_full, fifo_empty;
  ifq_entry_t  fifo_wdata, fifo_head;
  logic [CW-1:0] fifo_count;

  always_comb begin
    redirect_any = eret_valid || flush || redirect_valid;
    if (eret_valid) begin
      redirect_target = epc;
    end else if (flush) begin
      redirect_target = HANDLER_PC;
    end else begin
      redirect_target = redirect_pc;
    end
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;
    halt_d     = halt_q;
    fifo_clear = 1'b0;
    fifo_push  = 1'b0;
    fifo_wdata = '0;
    bypass     = 1'b0;

    pc_ok    = pc_legal(fetch_pc_q, SEG_LO, SEG_HI);
    slot_ok  = (fifo_count + CW'(inflight_q)) < CW'(DEPTH);
    rsp_fire = imem_rvalid && inflight_q;
    rsp_keep = rsp_fire && !discard_q;
    // A returning response frees the single outstanding slot in the same cycle.
    imem_req = reset && !redirect_any && !halt_q && !discard_q && pc_ok && slot_ok
               && (!inflight_q || imem_rvalid);
    req_fire  = imem_req && imem_gnt;
    adel_push = reset && !redirect_any && !halt_q && !pc_ok && !inflight_q && !fifo_full;

    if (rsp_fire) begin
      inflight_d = 1'b0;
      discard_d  = 1'b0;
    end

    if (redirect_any) begin
      fifo_clear = 1'b1;
      fetch_pc_d = redirect_target;
      halt_d     = 1'b0;
      if (inflight_q && !imem_rvalid) begin
        discard_d = 1'b1;
      end
    end else begin
      if (rsp_keep) begin
`ifdef IFQ_BYPASS_EN
        bypass = fifo_empty && if_ready;
`else
        bypass = 1'b0;
`endif
        fifo_push  = !bypass;
        fifo_wdata = '{instr: imem_rdata, pc: req_pc_q, exc: EXC_NONE};
      end
      if (adel_push) begin
        fifo_push  = 1'b1;
        fifo_wdata = '{instr: 32'd0, pc: fetch_pc_q, exc: EXC_ADEL};
        halt_d     = 1'b1;
      end
      if (req_fire) begin
        inflight_d = 1'b1;
        req_pc_d   = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
    end
  end

  always_comb begin
    imem_addr  = imem_req ? fetch_pc_q : 32'd0;
    fifo_pop   = if_ready && !fifo_empty;
    if_valid   = 1'b0;
    if_instr   = 32'd0;
    if_pc      = 32'd0;
    if_exccode = EXC_NONE;
    if (bypass) begin
      if_valid   = 1'b1;
      if_instr   = imem_rdata;
      if_pc      = req_pc_q;
      if_exccode = EXC_NONE;
    end else if (!fifo_empty) begin
      if_valid   = 1'b1;
      if_instr   = fifo_head.instr;
      if_pc      = fifo_head.pc;
      if_exccode = fifo_head.exc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= 32'd0;
      inflight_q <= 1'b0;
      discard_q  <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      halt_q     <= halt_d;
    end
  end

  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (fifo_clear),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
